// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: shared-counter multi-channel PWM, edge/center aligned, double-buffered config.
// Latency: outputs registered one clk behind the counter; period_done one clk after the boundary. No backpressure.
// Optional define PWM_DEADTIME_EN inserts per-channel dead time between pwm_out and pwm_out_n.
module pwm_multi_gen #(
   parameter int CNT_W = 32,
   parameter int N_CH  = 4,
   parameter int DT_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   pwm_gen_en,
   input  logic                   center_mode,
   input  logic                   cfg_wr,
   input  logic [CNT_W-1:0]       period_in,
   input  logic [N_CH*CNT_W-1:0]  cmp_in,
   input  logic [N_CH-1:0]        pol_in,
   input  logic [DT_W-1:0]        dead_time,
   output logic [N_CH-1:0]        pwm_out,
   output logic [N_CH-1:0]        pwm_out_n,
   output logic                   period_done
);

   logic [CNT_W-1:0]      per_sh, per_act;
   logic [N_CH*CNT_W-1:0] cmp_sh, cmp_act;
   logic [N_CH-1:0]       pol_sh, pol_act;
   logic                  mode_sh, mode_act;

   logic [CNT_W-1:0]      cnt, cnt_nxt, pe, cmp_cnt;
   logic                  dir_dn, dir_nxt;
   logic                  update;
   logic                  fall;
   logic [N_CH-1:0]       raw_nxt, raw_d, raw_q, pol_q;

   assign pe = (per_act == '0) ? CNT_W'(1) : per_act;

   always_comb begin
      cnt_nxt = cnt;
      dir_nxt = dir_dn;
      if (!mode_act) begin
         dir_nxt = 1'b0;
         if (cnt >= pe - CNT_W'(1))
            cnt_nxt = '0;
         else
            cnt_nxt = cnt + CNT_W'(1);
      end else if (!dir_dn && (cnt < pe)) begin
         cnt_nxt = cnt + CNT_W'(1);
      end else begin
         cnt_nxt = cnt - CNT_W'(1);
         dir_nxt = 1'b1;
      end
      if (cnt_nxt == '0)
         dir_nxt = 1'b0;
   end

   assign update = (cnt_nxt == '0);

   // On the falling half of the triangle (including the apex) compare cnt-1, so the
   // high window is exactly 2*min(cmp,Pe) cycles and cmp>=Pe gives a solid 100%.
   assign fall    = mode_act && (dir_dn || (cnt >= pe));
   assign cmp_cnt = fall ? (cnt - CNT_W'(1)) : cnt;

   always_comb begin
      raw_nxt = '0;
      for (int k = 0; k < N_CH; k++)
         raw_nxt[k] = (cmp_cnt < cmp_act[k*CNT_W +: CNT_W]);
   end

   assign raw_d = pwm_gen_en ? raw_nxt : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         per_sh      <= '0;
         cmp_sh      <= '0;
         pol_sh      <= '0;
         mode_sh     <= 1'b0;
         per_act     <= '0;
         cmp_act     <= '0;
         pol_act     <= '0;
         mode_act    <= 1'b0;
         cnt         <= '0;
         dir_dn      <= 1'b0;
         period_done <= 1'b0;
         raw_q       <= '0;
         pol_q       <= '0;
      end else begin
         if (cfg_wr) begin
            per_sh  <= period_in;
            cmp_sh  <= cmp_in;
            pol_sh  <= pol_in;
            mode_sh <= center_mode;
         end
         if (!pwm_gen_en) begin
            cnt         <= '0;
            dir_dn      <= 1'b0;
            period_done <= 1'b0;
         end else begin
            cnt         <= cnt_nxt;
            dir_dn      <= dir_nxt;
            period_done <= update;
         end
         // Shadow-to-active transfer uses the pre-write shadow, so a write on the
         // boundary edge waits for the following boundary.
         if (!pwm_gen_en || update) begin
            per_act  <= per_sh;
            cmp_act  <= cmp_sh;
            pol_act  <= pol_sh;
            mode_act <= mode_sh;
         end
         raw_q <= raw_d;
         pol_q <= pol_act;
      end
   end

`ifdef PWM_DEADTIME_EN
   logic [N_CH-1:0][DT_W-1:0] dt_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dt_cnt <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            if (raw_d[k] != raw_q[k])
               dt_cnt[k] <= dead_time;
            else if (dt_cnt[k] != '0)
               dt_cnt[k] <= dt_cnt[k] - DT_W'(1);
         end
      end
   end

   always_comb begin
      pwm_out   = '0;
      pwm_out_n = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (dt_cnt[k] != '0) begin
            pwm_out[k]   = pol_q[k];
            pwm_out_n[k] = pol_q[k];
         end else begin
            pwm_out[k]   = raw_q[k] ^ pol_q[k];
            pwm_out_n[k] = ~(raw_q[k] ^ pol_q[k]);
         end
      end
   end
`else
   logic dt_unused;
   assign dt_unused = ^dead_time;

   assign pwm_out   = raw_q ^ pol_q;
   assign pwm_out_n = ~pwm_out;
`endif

endmodule
